interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 24 ++
 rtl/interrupt_controller.sv | 102 ++++++++++
 tb/tb_interrupt_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the core/CSR side: requests, mask,
// PC and MRET in; trap redirect, CSR writes and peripheral acknowledge out.
interface interrupt_controller_if;
    logic [5:0]  int_req;
    logic [5:0]  mie;
    logic [31:0] pc;
    logic        mret;
    logic        int_o;
    logic [31:0] mcause;
    logic        en_mepc;
    logic [31:0] mepc_csr;
    logic [5:0]  int_rst;
    logic        busy;

    modport master (
        output int_req, mie, pc, mret,
        input  int_o, mcause, en_mepc, mepc_csr, int_rst, busy
    );

    modport slave (
        input  int_req, mie, pc, mret,
        output int_o, mcause, en_mepc, mepc_csr, int_rst, busy
    );
endinterface

// File: rtl/interrupt_controller.sv
// Six-line edge-triggered interrupt controller: latches rising edges as pending,
// dispatches one fixed-priority enabled line per trap, no nesting until MRET.
module interrupt_controller #(
    parameter int unsigned PRIO_LOW_FIRST = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    interrupt_controller_if.slave  bus
);
    localparam int unsigned NUM_LINES = 6;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRAP    = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  prev_req_q, prev_req_d;
    logic [5:0]  pending_q, pending_d;
    logic [2:0]  id_q, id_d;
    logic [31:0] mcause_q, mcause_d;

    logic [5:0]  rise;
    logic [5:0]  cand;
    logic [5:0]  id_onehot;
    logic [2:0]  sel;
    logic        found;
    logic        in_trap;

    assign rise      = bus.int_req & ~prev_req_q;
    assign cand      = pending_q & bus.mie;
    assign in_trap   = (state_q == TRAP);
    assign id_onehot = 6'(1) << id_q;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            idx = (PRIO_LOW_FIRST != 0) ? i : (NUM_LINES - 1 - i);
            if (!found && cand[idx[2:0]]) begin
                sel   = idx[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        mcause_d   = mcause_q;
        prev_req_d = bus.int_req;
        // A fresh edge on the line being cleared takes precedence over the clear.
        pending_d  = (pending_q & ~(in_trap ? id_onehot : 6'b0)) | rise;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = TRAP;
                    id_d    = sel;
                end
            end
            TRAP: begin
                state_d  = SERVICE;
                mcause_d = 32'h8000_0010 + {29'd0, id_q};
            end
            SERVICE: begin
                if (bus.mret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_req_q <= '0;
            pending_q  <= '0;
            id_q       <= '0;
            mcause_q   <= '0;
        end else begin
            state_q    <= state_d;
            prev_req_q <= prev_req_d;
            pending_q  <= pending_d;
            id_q       <= id_d;
            mcause_q   <= mcause_d;
        end
    end

    // Trap strobes decode straight from state so reset silences them at once.
    assign bus.int_o    = in_trap;
    assign bus.en_mepc  = in_trap;
    assign bus.mepc_csr = in_trap ? bus.pc : '0;
    assign bus.int_rst  = in_trap ? id_onehot : '0;
    assign bus.mcause   = mcause_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: every expected dispatch is queued
// when its request is driven and checked by a monitor when int_o fires.
module tb_interrupt_controller;
    logic clk;
    logic rst_n;

    interrupt_controller_if bus ();

    interrupt_controller #(.PRIO_LOW_FIRST(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mcause;
        logic [5:0]  int_rst;
        logic [31:0] mepc;
    } disp_t;

    disp_t       exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_disp(input int unsigned line);
        disp_t d;
        d.mcause  = 32'h8000_0010 + line;
        d.int_rst = 6'(1) << line;
        d.mepc    = bus.pc;
        exp_q.push_back(d);
    endtask

    // Advance to just after the next rising edge: drive and check point.
    task automatic cyc(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_int_o"},    32'(bus.int_o),   32'd0);
        check({tag, "_en_mepc"},  32'(bus.en_mepc), 32'd0);
        check({tag, "_mepc_csr"}, bus.mepc_csr,     32'd0);
        check({tag, "_int_rst"},  32'(bus.int_rst), 32'd0);
    endtask

    task automatic pulse_mret();
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
    endtask

    // Scoreboard monitor: strobes checked during TRAP, mcause one cycle later.
    logic        mcause_pending = 1'b0;
    logic [31:0] mcause_exp     = '0;
    always @(negedge clk) begin
        if (mcause_pending) begin
            check("mon_mcause", bus.mcause, mcause_exp);
            mcause_pending = 1'b0;
        end
        if (rst_n && bus.int_o) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_int_o", 32'(bus.int_o), 32'd0);
            end else begin
                disp_t d;
                d = exp_q.pop_front();
                check("mon_int_rst",  32'(bus.int_rst), 32'(d.int_rst));
                check("mon_en_mepc",  32'(bus.en_mepc), 32'd1);
                check("mon_mepc_csr", bus.mepc_csr,     d.mepc);
                check("mon_busy",     32'(bus.busy),    32'd1);
                mcause_exp     = d.mcause;
                mcause_pending = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        bus.int_req = '0;
        bus.mie     = 6'h3F;
        bus.pc      = 32'h100;
        bus.mret    = 1'b0;
        #1;
        check_idle_outs("reset");
        check("reset_busy",   32'(bus.busy), 32'd0);
        check("reset_mcause", bus.mcause,    32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc();

        // Single request on line 2, held high through MRET (level hold).
        bus.int_req = 6'b000100;
        expect_disp(2);
        cyc();
        check("single_lat_int_o", 32'(bus.int_o), 32'd0);
        check("single_lat_busy",  32'(bus.busy),  32'd0);
        cyc();
        check("single_int_o",    32'(bus.int_o),   32'd1);
        check("single_en_mepc",  32'(bus.en_mepc), 32'd1);
        check("single_mepc",     bus.mepc_csr,     32'h100);
        check("single_int_rst",  32'(bus.int_rst), 32'(6'b000100));
        cyc();
        check_idle_outs("single_svc");
        check("single_mcause", bus.mcause,    32'h8000_0012);
        check("single_busy",   32'(bus.busy), 32'd1);
        cyc(3);
        pulse_mret();
        check("single_mret_busy", 32'(bus.busy), 32'd0);
        cyc(4);
        check("level_hold_busy",  32'(bus.busy),  32'd0);
        check("level_hold_int_o", 32'(bus.int_o), 32'd0);
        bus.int_req = '0;
        cyc();

        // Priority: lines 5 and 1 together, line 1 wins.
        bus.pc      = 32'h200;
        bus.int_req = 6'b100010;
        expect_disp(1);
        expect_disp(5);
        cyc();
        bus.int_req = '0;
        cyc();
        check("prio_first_int_rst", 32'(bus.int_rst), 32'(6'b000010));
        cyc();
        check("prio_first_mcause", bus.mcause, 32'h8000_0011);
        pulse_mret();
        check("prio_gap_int_o", 32'(bus.int_o), 32'd0);
        check("prio_gap_busy",  32'(bus.busy),  32'd0);
        cyc();
        check("prio_second_int_rst", 32'(bus.int_rst), 32'(6'b100000));
        cyc();
        check("prio_second_mcause", bus.mcause, 32'h8000_0015);
        pulse_mret();

        // Masking: pulse on line 3 stays pending until enabled.
        bus.mie     = 6'h00;
        bus.int_req = 6'b001000;
        cyc();
        bus.int_req = '0;
        cyc(4);
        check("mask_int_o", 32'(bus.int_o), 32'd0);
        check("mask_busy",  32'(bus.busy),  32'd0);
        bus.mie = 6'h08;
        expect_disp(3);
        cyc();
        check("mask_trap_int_o", 32'(bus.int_o), 32'd1);
        cyc();
        check("mask_mcause", bus.mcause, 32'h8000_0013);
        pulse_mret();
        bus.mie = 6'h3F;
        cyc();

        // No nesting: line 0 raised during SERVICE of line 3.
        bus.int_req = 6'b001000;
        expect_disp(3);
        cyc();
        bus.int_req = '0;
        cyc(2);
        bus.int_req = 6'b000001;
        expect_disp(0);
        cyc();
        bus.int_req = '0;
        cyc(3);
        check("nest_int_o", 32'(bus.int_o), 32'd0);
        check("nest_busy",  32'(bus.busy),  32'd1);
        pulse_mret();
        check("nest_mret_busy", 32'(bus.busy), 32'd0);
        cyc();
        check("nest_trap_int_rst", 32'(bus.int_rst), 32'(6'b000001));
        cyc();
        check("nest_mcause", bus.mcause, 32'h8000_0010);
        pulse_mret();

        // Re-arm on the same line during its own TRAP: the set wins.
        bus.int_req = 6'b000010;
        expect_disp(1);
        cyc();
        bus.int_req = '0;
        cyc();
        bus.int_req = 6'b000010;
        expect_disp(1);
        check("rearm_trap_int_o", 32'(bus.int_o), 32'd1);
        cyc();
        bus.int_req = '0;
        pulse_mret();
        cyc();
        check("rearm_second_int_rst", 32'(bus.int_rst), 32'(6'b000010));
        cyc();
        pulse_mret();

        // Reset during TRAP; line 4 held high through release.
        bus.int_req = 6'b000100;
        cyc();
        bus.int_req = '0;
        cyc();
        check("rst_trap_int_o", 32'(bus.int_o), 32'd1);
        rst_n       = 1'b0;
        bus.int_req = 6'b010000;
        #1;
        check_idle_outs("rst_abort");
        check("rst_abort_busy",   32'(bus.busy), 32'd0);
        check("rst_abort_mcause", bus.mcause,    32'd0);
        cyc(2);
        check_idle_outs("rst_hold");
        rst_n = 1'b1;
        expect_disp(4);
        cyc();
        check("rst_first_edge_int_o", 32'(bus.int_o), 32'd0);
        cyc();
        check("rst_trap_int_rst", 32'(bus.int_rst), 32'(6'b010000));
        cyc();
        check("rst_mcause", bus.mcause, 32'h8000_0014);
        pulse_mret();
        bus.int_req = '0;
        cyc(3);
        check("final_busy", 32'(bus.busy), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
